// File: rtl/qspim_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qspim_rx_fifo
// Purpose  : Receive-data buffer sitting directly behind the QSPI RX shift
//            stage. Assembled 32-bit words enter through a valid/ready
//            handshake and are held in a small first-word-fall-through FIFO
//            for the bus-side read logic. The final word of each read
//            transfer is tagged with rd_last and byte enables derived from
//            the programmed byte count.
//
// Ports    :
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous clear of FIFO contents and transfer tracking
//   xfer_start in   one-cycle pulse, loads xfer_bytes for a new transfer
//   xfer_bytes in   [15:0] total bytes expected in the transfer
//   wr_valid   in   word available from the RX stage
//   wr_data    in   [DW-1:0] word from the RX stage, already byte-ordered
//   wr_ready   out  space available (one slot of headroom kept)
//   rd_valid   out  head word available
//   rd_data    out  [DW-1:0] head word
//   rd_be      out  [3:0] byte enables of the head word (lane 0 = [7:0])
//   rd_last    out  head word is the last word of the transfer
//   rd_ready   in   consumer pops the head when rd_valid && rd_ready
//   xfer_done  out  registered one-cycle pulse after the last word is popped
//   level      out  [AW:0] current word count, 0..DEPTH
//   overflow   out  sticky, a write arrived while full and was dropped
//
// Revision : 1.0  initial release
// ============================================================================
module qspim_rx_fifo #(
    parameter int DW    = 32,   // must stay 32: four byte lanes
    parameter int DEPTH = 4,    // power of two, >= 2
    parameter int AW    = 2     // log2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          xfer_start,
    input  logic [15:0]   xfer_bytes,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [3:0]    rd_be,
    output logic          rd_last,
    input  logic          rd_ready,
    output logic          xfer_done,
    output logic [AW:0]   level,
    output logic          overflow
);

    // Level value meaning "full" and the level at which wr_ready drops.
    localparam logic [AW:0] c_FULL       = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_HIGH_WATER = c_FULL - 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [14:0]   r_words_left;
    logic [1:0]    r_tail;
    logic          r_overflow;
    logic          r_xfer_done;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic        w_last;
    logic [14:0] w_words_load;

    assign w_full = (r_level == c_FULL);
    assign w_pop  = rd_valid && rd_ready && !flush;

    // A pop in the same cycle frees the head slot, so a write at full is
    // still accepted when the consumer is draining; the new word lands in
    // the slot being vacated (wr_ptr == rd_ptr when full).
    assign w_push = wr_valid && (!w_full || w_pop) && !flush;
    assign w_drop = wr_valid && w_full && !w_pop && !flush;

    assign w_last = rd_valid && (r_words_left == 15'd1);

    // ceil(xfer_bytes / 4)
    assign w_words_load = {1'b0, xfer_bytes[15:2]} + {14'd0, (xfer_bytes[1:0] != 2'd0)};

    // ------------------------------------------------------------------------
    // Storage: plain register array, no reset needed because rd_valid is
    // derived from level and never from the array contents.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, level, transfer tracking and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_words_left <= '0;
            r_tail       <= '0;
            r_overflow   <= 1'b0;
            r_xfer_done  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_words_left <= '0;
            r_tail       <= '0;
            r_overflow   <= 1'b0;
            r_xfer_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            // A new transfer load overrides the decrement of a coincident pop.
            if (xfer_start) begin
                r_words_left <= w_words_load;
                r_tail       <= xfer_bytes[1:0];
            end else if (w_pop && (r_words_left != 15'd0)) begin
                r_words_left <= r_words_left - 15'd1;
            end

            r_xfer_done <= w_pop && w_last;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign xfer_done = r_xfer_done;
    assign rd_valid  = (r_level != '0);
    assign rd_data   = r_mem[r_rd_ptr];
    assign rd_last   = w_last;

    // Headroom of one slot: the RX stage raises data_valid a cycle after it
    // samples data_ready, so one more word may still arrive after the drop.
    assign wr_ready  = (r_level < c_HIGH_WATER);

    // Partial byte enables only on the final word of a transfer whose byte
    // count is not a multiple of four.
    always_comb begin
        rd_be = 4'hF;
        if (w_last) begin
            case (r_tail)
                2'd1:    rd_be = 4'b0001;
                2'd2:    rd_be = 4'b0011;
                2'd3:    rd_be = 4'b0111;
                default: rd_be = 4'hF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qspim_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspim_rx_fifo
// Purpose  : Directed self-checking bench for qspim_rx_fifo with
//            hand-computed expected values.
// Revision : 1.0  initial release
// ============================================================================
module tb_qspim_rx_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          xfer_start;
    logic [15:0]   xfer_bytes;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [3:0]    rd_be;
    logic          rd_last;
    logic          rd_ready;
    logic          xfer_done;
    logic [AW:0]   level;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    qspim_rx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .xfer_start (xfer_start),
        .xfer_bytes (xfer_bytes),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_be      (rd_be),
        .rd_last    (rd_last),
        .rd_ready   (rd_ready),
        .xfer_done  (xfer_done),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled on the
    // falling edge or 1 ns after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [15:0] bytes);
        xfer_start = 1'b1;
        xfer_bytes = bytes;
        next_cycle();
        xfer_start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        next_cycle();
        wr_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] d,
                             input logic [3:0] be, input logic last);
        rd_ready = 1'b1;
        @(negedge clk);
        check_value({tag, ".valid"}, 32'(rd_valid), 32'd1);
        check_value({tag, ".data"},  rd_data, d);
        check_value({tag, ".be"},    32'(rd_be), 32'(be));
        check_value({tag, ".last"},  32'(rd_last), 32'(last));
        next_cycle();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        xfer_start = 1'b0;
        xfer_bytes = 16'd0;
        wr_valid   = 1'b0;
        wr_data    = 32'd0;
        rd_ready   = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // ---------------- reset / idle ----------------
        check_value("rst.rd_valid",  32'(rd_valid), 32'd0);
        check_value("rst.wr_ready",  32'(wr_ready), 32'd1);
        check_value("rst.level",     32'(level), 32'd0);
        check_value("rst.rd_be",     32'(rd_be), 32'hF);
        check_value("rst.overflow",  32'(overflow), 32'd0);
        check_value("rst.rd_last",   32'(rd_last), 32'd0);
        check_value("rst.xfer_done", 32'(xfer_done), 32'd0);

        // ---------------- 10-byte transfer: 3 words, tail 2 ----------------
        start_xfer(16'd10);
        push(32'h1111_1111);
        check_value("t10.lat_valid", 32'(rd_valid), 32'd1);
        check_value("t10.lat_data",  rd_data, 32'h1111_1111);
        push(32'h2222_2222);
        push(32'h3333_3333);
        check_value("t10.level3",    32'(level), 32'd3);
        check_value("t10.wr_ready3", 32'(wr_ready), 32'd0);
        pop_check("t10.p1", 32'h1111_1111, 4'hF, 1'b0);
        check_value("t10.done_p1", 32'(xfer_done), 32'd0);
        check_value("t10.wr_ready2", 32'(wr_ready), 32'd1);
        pop_check("t10.p2", 32'h2222_2222, 4'hF, 1'b0);
        check_value("t10.done_p2", 32'(xfer_done), 32'd0);
        pop_check("t10.p3", 32'h3333_3333, 4'b0011, 1'b1);
        check_value("t10.done_hi", 32'(xfer_done), 32'd1);
        check_value("t10.empty",   32'(rd_valid), 32'd0);
        next_cycle();
        check_value("t10.done_lo", 32'(xfer_done), 32'd0);

        // ---------------- fill, push+pop at full, overflow ----------------
        push(32'hA000_0001);
        push(32'hA000_0002);
        push(32'hA000_0003);
        check_value("full.wr_ready3", 32'(wr_ready), 32'd0);
        push(32'hA000_0004);
        check_value("full.level4",    32'(level), 32'd4);
        check_value("full.ovf4",      32'(overflow), 32'd0);
        // simultaneous push and pop at full
        wr_valid = 1'b1;
        wr_data  = 32'hB000_0005;
        rd_ready = 1'b1;
        @(negedge clk);
        check_value("full.pp_head", rd_data, 32'hA000_0001);
        next_cycle();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check_value("full.pp_level", 32'(level), 32'd4);
        check_value("full.pp_ovf",   32'(overflow), 32'd0);
        // write while full with no pop: dropped
        push(32'hDEAD_BEEF);
        check_value("full.drop_level", 32'(level), 32'd4);
        check_value("full.drop_ovf",   32'(overflow), 32'd1);
        pop_check("full.p2", 32'hA000_0002, 4'hF, 1'b0);
        pop_check("full.p3", 32'hA000_0003, 4'hF, 1'b0);
        pop_check("full.p4", 32'hA000_0004, 4'hF, 1'b0);
        pop_check("full.p5", 32'hB000_0005, 4'hF, 1'b0);
        check_value("full.ovf_sticky", 32'(overflow), 32'd1);
        check_value("full.level0",     32'(level), 32'd0);
        // pop on empty is ignored
        rd_ready = 1'b1;
        next_cycle();
        rd_ready = 1'b0;
        check_value("empty.pop_level", 32'(level), 32'd0);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check_value("flush.ovf_clr", 32'(overflow), 32'd0);

        // ---------------- pointer wrap, 24 bytes -> 6 words ----------------
        start_xfer(16'd24);
        push(32'hC000_0001);
        push(32'hC000_0002);
        pop_check("wrap.p1", 32'hC000_0001, 4'hF, 1'b0);
        push(32'hC000_0003);
        pop_check("wrap.p2", 32'hC000_0002, 4'hF, 1'b0);
        push(32'hC000_0004);
        push(32'hC000_0005);
        pop_check("wrap.p3", 32'hC000_0003, 4'hF, 1'b0);
        push(32'hC000_0006);
        pop_check("wrap.p4", 32'hC000_0004, 4'hF, 1'b0);
        pop_check("wrap.p5", 32'hC000_0005, 4'hF, 1'b0);
        pop_check("wrap.p6", 32'hC000_0006, 4'hF, 1'b1);
        check_value("wrap.done", 32'(xfer_done), 32'd1);

        // ---------------- 7 bytes -> 2 words, tail 3; then 5 bytes, tail 1 ----
        start_xfer(16'd7);
        push(32'hE000_0001);
        push(32'hE000_0002);
        pop_check("t7.p1", 32'hE000_0001, 4'hF, 1'b0);
        pop_check("t7.p2", 32'hE000_0002, 4'b0111, 1'b1);
        start_xfer(16'd5);
        push(32'hE100_0001);
        push(32'hE100_0002);
        pop_check("t5.p1", 32'hE100_0001, 4'hF, 1'b0);
        pop_check("t5.p2", 32'hE100_0002, 4'b0001, 1'b1);

        // ---------------- zero-byte transfer: words pass, never last ----------
        start_xfer(16'd0);
        push(32'hF000_0001);
        pop_check("t0.p1", 32'hF000_0001, 4'hF, 1'b0);
        check_value("t0.done", 32'(xfer_done), 32'd0);

        // ---------------- flush mid-transfer with push and xfer_start ---------
        start_xfer(16'd12);
        push(32'h5000_0001);
        push(32'h5000_0002);
        check_value("fl.level2", 32'(level), 32'd2);
        flush      = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 32'h5000_0003;
        xfer_start = 1'b1;
        xfer_bytes = 16'd40;
        next_cycle();
        flush      = 1'b0;
        wr_valid   = 1'b0;
        xfer_start = 1'b0;
        check_value("fl.level",    32'(level), 32'd0);
        check_value("fl.rd_valid", 32'(rd_valid), 32'd0);
        check_value("fl.overflow", 32'(overflow), 32'd0);
        check_value("fl.wr_ready", 32'(wr_ready), 32'd1);
        check_value("fl.done",     32'(xfer_done), 32'd0);
        // words_left was cleared: a lone word must not be tagged last
        push(32'h5000_0004);
        pop_check("fl.p1", 32'h5000_0004, 4'hF, 1'b0);
        check_value("fl.done2", 32'(xfer_done), 32'd0);

        // ---------------- async reset mid-transfer ----------------
        start_xfer(16'd8);
        push(32'h6000_0001);
        push(32'h6000_0002);
        #2;
        rst = 1'b1;
        #1;
        check_value("arst.level",    32'(level), 32'd0);
        check_value("arst.rd_valid", 32'(rd_valid), 32'd0);
        check_value("arst.wr_ready", 32'(wr_ready), 32'd1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        push(32'h6000_0003);
        pop_check("arst.p1", 32'h6000_0003, 4'hF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qspim_rx_fifo.md
Name: qspim_rx_fifo

Overview:
- Receive-data buffer directly downstream of the QSPI RX shift stage.
- Accepts 32-bit assembled words through a valid/ready handshake; its ready output drives the RX stage's data_ready input.
- Buffers the words in a small FIFO and presents them to the bus-side read logic.
- Tags the final word of each transfer with last and byte-enable information derived from the programmed byte count.

Parameters:
- DW, 32, data word width; must stay 32 (byte-enable logic is 4 lanes).
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of FIFO contents and transfer tracking.
- xfer_start  input  1  one-cycle pulse: new read transfer begins; loads xfer_bytes.
- xfer_bytes  input  16  total bytes expected in the transfer.
- wr_valid  input  1  word available from RX stage (its data_valid).
- wr_data  input  32  word from RX stage, already byte-ordered.
- wr_ready  output  1  space available; drives RX stage data_ready.
- rd_valid  output  1  head word available.
- rd_data  output  32  head word.
- rd_be  output  4  byte enables of head word.
- rd_last  output  1  head word is the last word of the transfer.
- rd_ready  input  1  consumer pops head word when rd_valid && rd_ready.
- xfer_done  output  1  one-cycle pulse, registered, after the last word is popped.
- level  output  AW+1  current word count, 0..DEPTH.
- overflow  output  1  sticky: a write arrived while full and was dropped.

Behaviour:
- Reset (rst high, async): pointers=0, level=0, words_left=0, overflow=0, xfer_done=0. Outputs: wr_ready=1, rd_valid=0, rd_last=0, rd_be=4'hF. rd_data is don't-care but must not be X-dependent for valid.
- Storage: DEPTH x 32 register array, first-word fall-through.
  - rd_data = mem[rd_ptr] combinationally; rd_valid = (level != 0).
  - A written word is visible on rd_data/rd_valid the cycle after the write edge (1-cycle latency).
- wr_ready = (level < DEPTH-1), combinational from level.
  - This one-slot headroom is required: the RX stage registers data_valid one cycle after sampling data_ready.
- Push = wr_valid && (level != DEPTH).
  - wr_valid while level == DEPTH: word dropped, overflow set to 1; it stays set until flush or rst.
- Pop = rd_valid && rd_ready. rd_ready with level == 0 is ignored.
- Simultaneous push and pop: level unchanged, both pointers advance. This is legal at level == DEPTH (pop frees the slot, so no overflow) and at level == 1.
- Pointers wrap modulo DEPTH.
- Transfer tracking: words_left is a 15-bit register.
  - On xfer_start, load words_left = ceil(xfer_bytes/4) = xfer_bytes[15:2] + (xfer_bytes[1:0] != 0); also latch tail = xfer_bytes[1:0].
  - Each pop with words_left != 0 decrements words_left by 1. Pops with words_left == 0 do not change it.
  - xfer_start in the same cycle as a pop: the load wins; the pop still moves the FIFO.
- rd_last = rd_valid && (words_left == 1).
- rd_be = 4'hF, except when rd_last && tail != 0: tail 1 -> 4'b0001, 2 -> 4'b0011, 3 -> 4'b0111. Lane 0 is rd_data[7:0].
- xfer_done is registered and asserted for exactly one cycle after a pop with rd_last=1.
- xfer_bytes == 0: words_left = 0, rd_last never asserts, xfer_done never fires; the FIFO still passes words.
- flush (synchronous): clears pointers, level, words_left, tail and overflow; xfer_done is forced to 0.
  - flush has priority over push, pop and xfer_start in the same cycle.
  - A wr_valid coinciding with flush is discarded.
- rst asserted mid-transfer: immediate return to the reset state; no partial state is retained.

Test Plan:
- Reset then idle: rd_valid=0, wr_ready=1, level=0, rd_be=F, overflow=0.
- xfer_start with xfer_bytes=10, push words 0x11111111, 0x22222222, 0x33333333, pop each: third pop shows rd_last=1, rd_be=0011; xfer_done pulses one cycle after the third pop; first two pops show rd_be=F, rd_last=0.
- DEPTH=4, push 3 words with no pops: wr_ready drops when level=3. Push a 4th: level=4, overflow stays 0. Push a 5th while full: dropped, overflow=1, rd_data order 1,2,3,4 preserved.
- At level=4, assert wr_valid and rd_ready together: level stays 4, overflow=0, new word appears after the 3 older words.
- Push 6 words with interleaved pops to force pointer wrap: rd_data sequence exactly matches write order; xfer_bytes=24 gives rd_last on the 6th word with rd_be=F.
- Mid-transfer (level=2, words_left=3), assert flush together with wr_valid and xfer_start: next cycle level=0, rd_valid=0, words_left=0, overflow=0, no xfer_done.
